// File: rtl/axil_reg_master.sv
// AXI4-Lite slave to reg_ifc master bridge: one transaction in flight, reads and
// writes alternate on collision, single-cycle rd/wr strobes toward the register slave.
module axil_reg_master #(
  parameter int AWIDTH = 2,
  parameter int DWIDTH = 32,
  parameter int AXI_AW = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [AXI_AW-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [AXI_AW-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [DWIDTH-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  output logic [AWIDTH-1:0] reg_waddr,
  output logic [DWIDTH-1:0] reg_wdata,
  output logic              reg_wr,
  output logic [AWIDTH-1:0] reg_raddr,
  output logic              reg_rd,
  input  logic [DWIDTH-1:0] reg_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_BRESP, S_RD, S_RWAIT, S_RRESP} state_t;
  typedef enum logic {G_READ, G_WRITE} grant_t;

  state_t            state_q, state_d;
  grant_t            last_q, last_d;
  logic              reg_wr_q, reg_wr_d;
  logic              reg_rd_q, reg_rd_d;
  logic [AWIDTH-1:0] waddr_q, waddr_d;
  logic [AWIDTH-1:0] raddr_q, raddr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;

  logic wr_req, rd_req, grant_wr, grant_rd;

  // Only the word-index bits reach the register slave; the rest alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{awaddr[AXI_AW-1:AWIDTH+2], awaddr[1:0],
                              araddr[AXI_AW-1:AWIDTH+2], araddr[1:0]};

  assign wr_req   = awvalid && wvalid;
  assign rd_req   = arvalid;
  // On collision the side that did not win last time goes first.
  assign grant_wr = wr_req && (!rd_req || (last_q == G_READ));
  assign grant_rd = rd_req && (!wr_req || (last_q == G_WRITE));

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    reg_wr_d = 1'b0;
    reg_rd_d = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    raddr_d  = raddr_q;
    rdata_d  = rdata_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    rvalid_d = rvalid_q;
    awready  = 1'b0;
    wready   = 1'b0;
    arready  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_wr) begin
          awready  = 1'b1;
          wready   = 1'b1;
          waddr_d  = awaddr[AWIDTH+1:2];
          wdata_d  = wdata;
          // Partial strobes are refused: no register write, SLVERR back.
          reg_wr_d = (wstrb == 4'hF);
          bresp_d  = (wstrb == 4'hF) ? 2'b00 : 2'b10;
          last_d   = G_WRITE;
          state_d  = S_WR;
        end else if (grant_rd) begin
          arready  = 1'b1;
          raddr_d  = araddr[AWIDTH+1:2];
          reg_rd_d = 1'b1;
          last_d   = G_READ;
          state_d  = S_RD;
        end
      end
      S_WR: begin
        bvalid_d = 1'b1;
        state_d  = S_BRESP;
      end
      S_BRESP: begin
        if (bready) begin
          bvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      S_RD:    state_d = S_RWAIT;
      S_RWAIT: begin
        rdata_d  = reg_rdata;
        rvalid_d = 1'b1;
        state_d  = S_RRESP;
      end
      S_RRESP: begin
        if (rready) begin
          rvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      last_q   <= G_READ;
      reg_wr_q <= 1'b0;
      reg_rd_q <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      raddr_q  <= '0;
      rdata_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      reg_wr_q <= reg_wr_d;
      reg_rd_q <= reg_rd_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      raddr_q  <= raddr_d;
      rdata_q  <= rdata_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign reg_wr    = reg_wr_q;
  assign reg_rd    = reg_rd_q;
  assign reg_waddr = waddr_q;
  assign reg_wdata = wdata_q;
  assign reg_raddr = raddr_q;
  assign rdata     = rdata_q;
  assign rresp     = 2'b00;
  assign bvalid    = bvalid_q;
  assign bresp     = bresp_q;
  assign rvalid    = rvalid_q;

endmodule

// File: tb/tb_axil_reg_master.sv
// Directed + randomized bench for axil_reg_master against a word-array register model.
module tb_axil_reg_master;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic [31:0]   awaddr, wdata, araddr, rdata, reg_wdata, reg_rdata;
  logic [3:0]    wstrb;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready, reg_wr, reg_rd;
  logic [1:0]    bresp, rresp;
  logic [AW-1:0] reg_waddr, reg_raddr;

  axil_reg_master #(.AWIDTH(AW), .DWIDTH(32), .AXI_AW(32)) dut (
    .clk(clk), .rstn(rstn),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .reg_wr(reg_wr),
    .reg_raddr(reg_raddr), .reg_rd(reg_rd), .reg_rdata(reg_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] slv_mem   [4];  // the register slave behind the bridge
  logic [31:0] model_mem [4];  // what the bench expects that slave to hold

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Register slave and strobe monitor, evaluated mid-cycle.
  int          wr_cnt = 0, rd_cnt = 0, wr_cyc = 0, rd_cyc = 0;
  logic [1:0]  wr_addr, rd_addr, pend_addr;
  logic [31:0] wr_data;
  bit          prev_wr = 0, prev_rd = 0, rd_pend = 0;

  always @(negedge clk) begin
    if (!rstn) begin
      prev_wr = 0; prev_rd = 0; rd_pend = 0;
      reg_rdata = $urandom;
    end else begin
      // data valid only in the cycle right after the rd strobe
      reg_rdata = rd_pend ? slv_mem[pend_addr] : $urandom;
      rd_pend   = reg_rd;
      pend_addr = reg_raddr;
      if (reg_wr || reg_rd) begin
        chk("rd_wr_exclusive", {31'b0, reg_wr && reg_rd}, 0);
        chk("wr_single_pulse", {31'b0, reg_wr && prev_wr}, 0);
        chk("rd_single_pulse", {31'b0, reg_rd && prev_rd}, 0);
      end
      if (reg_wr) begin
        slv_mem[reg_waddr] = reg_wdata;
        wr_cnt++; wr_cyc = cyc; wr_addr = reg_waddr; wr_data = reg_wdata;
      end
      if (reg_rd) begin
        rd_cnt++; rd_cyc = cyc; rd_addr = reg_raddr;
      end
      prev_wr = reg_wr; prev_rd = reg_rd;
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_reg_wr"}, {31'b0, reg_wr}, 0);
    chk({tag, "_reg_rd"}, {31'b0, reg_rd}, 0);
    chk({tag, "_reg_waddr"}, {30'b0, reg_waddr}, 0);
    chk({tag, "_reg_raddr"}, {30'b0, reg_raddr}, 0);
    chk({tag, "_reg_wdata"}, reg_wdata, 0);
    chk({tag, "_bvalid"}, {31'b0, bvalid}, 0);
    chk({tag, "_bresp"}, {30'b0, bresp}, 0);
    chk({tag, "_rvalid"}, {31'b0, rvalid}, 0);
    chk({tag, "_rdata"}, rdata, 0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int bhold);
    int  t0, tb, wc0;
    bit  ok;
    bit  full;
    full = (strb == 4'hF);
    wc0  = wr_cnt;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1; wvalid = 1; bready = (bhold == 0);
    #1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (awready) begin ok = 1; break; end
      step();
    end
    chk("aw_accept_timeout", {31'b0, ok}, 1);
    chk("wready_with_awready", {31'b0, wready}, {31'b0, awready});
    t0 = cyc;
    step();
    awvalid = 0; wvalid = 0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (bvalid) begin ok = 1; break; end
      step();
    end
    chk("bvalid_timeout", {31'b0, ok}, 1);
    tb = cyc;
    chk("b_latency", tb - t0, 2);
    chk("bresp", {30'b0, bresp}, full ? 0 : 2);
    for (int k = 0; k < bhold; k++) begin
      chk("bvalid_held", {31'b0, bvalid}, 1);
      chk("bresp_held", {30'b0, bresp}, full ? 0 : 2);
      chk("arready_blocked", {31'b0, arready}, 0);
      step();
    end
    bready = 1;
    step();
    bready = 0;
    #1;
    chk("bvalid_clear", {31'b0, bvalid}, 0);
    chk("wr_pulse_count", wr_cnt - wc0, full ? 1 : 0);
    if (full) begin
      chk("wr_pulse_cycle", wr_cyc - t0, 1);
      chk("reg_waddr", {30'b0, wr_addr}, {30'b0, addr[3:2]});
      chk("reg_wdata", wr_data, data);
      model_mem[addr[3:2]] = data;
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input int rhold);
    int          t0, tr, rc0;
    bit          ok;
    logic [31:0] exp;
    exp = model_mem[addr[3:2]];
    rc0 = rd_cnt;
    araddr = addr; arvalid = 1; rready = (rhold == 0);
    #1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (arready) begin ok = 1; break; end
      step();
    end
    chk("ar_accept_timeout", {31'b0, ok}, 1);
    t0 = cyc;
    step();
    arvalid = 0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (rvalid) begin ok = 1; break; end
      step();
    end
    chk("rvalid_timeout", {31'b0, ok}, 1);
    tr = cyc;
    chk("r_latency", tr - t0, 3);
    chk("rdata", rdata, exp);
    chk("rresp", {30'b0, rresp}, 0);
    for (int k = 0; k < rhold; k++) begin
      chk("rvalid_held", {31'b0, rvalid}, 1);
      chk("rdata_held", rdata, exp);
      chk("awready_blocked", {31'b0, awready}, 0);
      step();
    end
    rready = 1;
    step();
    rready = 0;
    #1;
    chk("rvalid_clear", {31'b0, rvalid}, 0);
    chk("rd_pulse_count", rd_cnt - rc0, 1);
    chk("rd_pulse_cycle", rd_cyc - t0, 1);
    chk("reg_raddr", {30'b0, rd_addr}, {30'b0, addr[3:2]});
  endtask

  initial begin
    int rc0;
    for (int i = 0; i < 4; i++) begin slv_mem[i] = 0; model_mem[i] = 0; end
    rstn = 0;
    awaddr = 0; wdata = 0; wstrb = 0; awvalid = 0; wvalid = 0; bready = 0;
    araddr = 0; arvalid = 0; rready = 0;
    step(); step();
    chk_reset_outputs("reset");
    chk("reset_awready", {31'b0, awready}, 0);
    rstn = 1;
    step();

    // Collision from reset: write wins, then the next collision goes to the read.
    awaddr = 32'h8; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 32'h8; arvalid = 1; bready = 1;
    #1;
    chk("collide1_awready", {31'b0, awready}, 1);
    chk("collide1_arready", {31'b0, arready}, 0);
    do_write(32'h8, 32'hDEADBEEF, 4'hF, 0);
    awaddr = 32'h0; wdata = 32'hA5A5_0001; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    #1;
    chk("collide2_arready", {31'b0, arready}, 1);
    chk("collide2_awready", {31'b0, awready}, 0);
    do_read(32'h8, 0);
    do_write(32'h0, 32'hA5A5_0001, 4'hF, 0);

    // Read whose data comes from the slave one cycle after the strobe.
    slv_mem[1] = 32'h12345678; model_mem[1] = 32'h12345678;
    do_read(32'h4, 0);

    // B held under backpressure blocks a pending read.
    araddr = 32'hC; arvalid = 1;
    do_write(32'hC, 32'hCAFE_F00D, 4'hF, 10);
    arvalid = 1;
    #1;
    chk("ar_after_bhandshake", {31'b0, arready}, 1);
    do_read(32'hC, 2);

    // Partial strobe: no register write, SLVERR.
    do_write(32'h4, 32'h0BAD_0BAD, 4'h3, 0);
    do_read(32'h4, 0);

    // AW without W is not accepted.
    awaddr = 32'h8; awvalid = 1; wvalid = 0;
    for (int k = 0; k < 5; k++) begin
      chk("aw_without_w", {31'b0, awready}, 0);
      step();
    end
    do_write(32'h8, 32'h5555_AAAA, 4'hF, 1);

    // Reset in the RWAIT cycle of a read.
    araddr = 32'h8; arvalid = 1; rready = 1;
    #1;
    chk("pre_reset_arready", {31'b0, arready}, 1);
    step(); arvalid = 0;
    step();
    rstn = 0;
    #1;
    chk_reset_outputs("midreset");
    step(); step();
    rstn = 1;
    rc0 = rd_cnt;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("post_reset_rvalid", {31'b0, rvalid}, 0);
    end
    chk("post_reset_no_rd", rd_cnt - rc0, 0);
    rready = 0;
    do_read(32'h8, 1);

    // Randomized traffic, upper address bits exercise aliasing.
    for (int n = 0; n < 30; n++) begin
      logic [31:0] a, d;
      logic [3:0]  s;
      a = $urandom; d = $urandom;
      s = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
      if ($urandom_range(0, 1) == 1) do_write(a, d, s, $urandom_range(0, 3));
      else                           do_read(a, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
